pixel_read_buffer: RTL and testbench



---
 rtl/pixel_read_buffer_pkg.sv | 15 +
 rtl/pixel_read_buffer_flex_counter.sv | 28 ++
 rtl/pixel_read_buffer.sv | 143 ++++++++++++++
 tb/tb_pixel_read_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_read_buffer_pkg.sv
// Shared definitions for the pixel read/write buffers: FSM state encoding and
// default image geometry, so both sides agree on the image layout.
package pixel_read_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        UNPACK = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned DEF_IMG_WIDTH  = 80;
    localparam int unsigned DEF_IMG_HEIGHT = 60;

endpackage

// File: rtl/pixel_read_buffer_flex_counter.sv
// Modulo counter with synchronous clear; at_max flags the last count before wrap.
module flex_counter #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned MODULUS  = 256
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    output logic [NUM_BITS-1:0] count,
    output logic                at_max
);

    localparam logic [NUM_BITS-1:0] LAST = NUM_BITS'(MODULUS - 1);

    assign at_max = (count == LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= at_max ? '0 : count + NUM_BITS'(1);
        end
    end

endmodule

// File: rtl/pixel_read_buffer.sv
// Fetches packed 4-pixel words from SRAM and streams them out one pixel at a
// time (MSB byte first) with row/column position and an end-of-image pulse.
module pixel_read_buffer
    import pixel_read_buffer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic        read_en,
    output logic [31:0] read_addr,
    input  logic [31:0] read_data,
    input  logic        read_valid,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  row_idx,
    output logic [7:0]  col_idx,
    output logic        busy,
    output logic        img_done
);

    localparam int unsigned WORDS_PER_ROW = IMG_WIDTH / 4;
    localparam int unsigned TOTAL_WORDS   = WORDS_PER_ROW * IMG_HEIGHT;
    localparam logic [15:0] LAST_WORD     = 16'(TOTAL_WORDS);

    state_t      state;
    logic [31:0] base_addr;
    logic [31:0] word_reg;
    logic [1:0]  byte_idx;
    logic [15:0] word_cnt;

    logic accept;
    logic last_accept;
    logic col_clear;
    logic col_at_max;

    // word_cnt has already been bumped for the word being unpacked, so a match
    // on the final byte means the whole image has been delivered.
    always_comb begin
        accept      = 1'b0;
        last_accept = 1'b0;
        col_clear   = 1'b0;
        if (state == UNPACK && pix_ready) begin
            accept      = 1'b1;
            last_accept = (byte_idx == 2'd3) && (word_cnt == LAST_WORD);
        end
        col_clear = ((state == IDLE) && start) || last_accept;
    end

    flex_counter #(
        .NUM_BITS (8),
        .MODULUS  (IMG_WIDTH)
    ) u_col_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (col_clear),
        .count_enable (accept),
        .count        (col_idx),
        .at_max       (col_at_max)
    );

    always_comb begin
        pix_out = '0;
        case (byte_idx)
            2'd0:    pix_out = word_reg[31:24];
            2'd1:    pix_out = word_reg[23:16];
            2'd2:    pix_out = word_reg[15:8];
            default: pix_out = word_reg[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            base_addr <= '0;
            word_reg  <= '0;
            byte_idx  <= '0;
            word_cnt  <= '0;
            row_idx   <= '0;
            read_en   <= 1'b0;
            read_addr <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            img_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        base_addr <= start_addr;
                        read_addr <= start_addr;
                        read_en   <= 1'b1;
                        busy      <= 1'b1;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        row_idx   <= '0;
                    end
                end
                REQ: begin
                    if (read_valid) begin
                        state     <= UNPACK;
                        word_reg  <= read_data;
                        byte_idx  <= '0;
                        word_cnt  <= word_cnt + 16'd1;
                        read_en   <= 1'b0;
                        pix_valid <= 1'b1;
                    end
                end
                UNPACK: begin
                    if (pix_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (col_at_max) begin
                            row_idx <= row_idx + 9'd1;
                        end
                        if (byte_idx == 2'd3) begin
                            pix_valid <= 1'b0;
                            if (word_cnt == LAST_WORD) begin
                                state    <= DONE;
                                img_done <= 1'b1;
                                row_idx  <= '0;
                            end else begin
                                state     <= REQ;
                                read_en   <= 1'b1;
                                read_addr <= base_addr + {14'd0, word_cnt, 2'b00};
                            end
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    img_done <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_read_buffer.sv
// Directed bench for pixel_read_buffer on an 8x2 image with an SRAM responder
// and a pixel scoreboard filled as each word is returned.
module tb_pixel_read_buffer;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 2;
    localparam int          NPIX = W * H;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic        read_en;
    logic [31:0] read_addr;
    logic [31:0] read_data = '0;
    logic        read_valid = 1'b0;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [8:0]  row_idx;
    logic [7:0]  col_idx;
    logic        busy;
    logic        img_done;

    typedef struct {
        logic [7:0] pix;
        logic [8:0] row;
        logic [7:0] col;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_addr, held_addr;
    bit  req_seen, rv_prev, spur_done;
    int  lat_cnt, words_served, accepted, done_pulses;
    int  slow_word, slow_lat, stall_at, stall_left, spur_at;

    pixel_read_buffer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .start_addr (start_addr),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_valid (read_valid),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .busy       (busy),
        .img_done   (img_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_data(input int k);
        if (k == 0) return 32'hAABBCCDD;
        return 32'h11223344 + 32'(k) * 32'h01010101;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_read_en"},   32'(read_en),   32'h0);
        check({tag, "_read_addr"}, read_addr,      32'h0);
        check({tag, "_pix_out"},   32'(pix_out),   32'h0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'h0);
        check({tag, "_row_idx"},   32'(row_idx),   32'h0);
        check({tag, "_col_idx"},   32'(col_idx),   32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_img_done"},  32'(img_done),  32'h0);
    endtask

    // One clock: drive inputs for the coming posedge, then judge the outputs
    // that were settled by the previous posedge against those inputs.
    task automatic cycle();
        exp_t e;
        int   p;
        @(negedge clk);
        start      = 1'b0;
        read_valid = 1'b0;
        if (rv_prev) check("pix_valid_after_read", 32'(pix_valid), 32'h1);
        rv_prev = 1'b0;

        if (read_en) begin
            check("pix_valid_during_req", 32'(pix_valid), 32'h0);
            if (!req_seen) begin
                check("read_addr", read_addr, exp_addr);
                req_seen  = 1'b1;
                held_addr = read_addr;
                lat_cnt   = 0;
            end else begin
                check("read_addr_stable", read_addr, held_addr);
            end
            if (lat_cnt >= ((words_served == slow_word) ? slow_lat : 1)) begin
                read_valid = 1'b1;
                read_data  = word_data(words_served);
                for (int b = 0; b < 4; b++) begin
                    p     = words_served * 4 + b;
                    e.pix = read_data[31 - 8*b -: 8];
                    e.row = 9'(p / W);
                    e.col = 8'(p % W);
                    exp_q.push_back(e);
                end
                words_served++;
                exp_addr = exp_addr + 32'd4;
                req_seen = 1'b0;
                rv_prev  = 1'b1;
            end else begin
                lat_cnt++;
            end
        end

        if (!spur_done && pix_valid && accepted == spur_at) begin
            start      = 1'b1;
            start_addr = 32'h999;
            read_valid = 1'b1;
            read_data  = 32'hDEADBEEF;
            spur_done  = 1'b1;
        end

        pix_ready = 1'b1;
        if (pix_valid && accepted == stall_at && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
            if (exp_q.size() > 0) begin
                check("stall_pix_out", 32'(pix_out), 32'(exp_q[0].pix));
                check("stall_col_idx", 32'(col_idx), 32'(exp_q[0].col));
            end
            check("stall_no_read", 32'(read_en), 32'h0);
        end

        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check("pix_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("pix_out", 32'(pix_out), 32'(e.pix));
                check("row_idx", 32'(row_idx), 32'(e.row));
                check("col_idx", 32'(col_idx), 32'(e.col));
            end
            accepted++;
        end

        if (img_done) begin
            done_pulses++;
            check("done_row_idx",   32'(row_idx),   32'h0);
            check("done_col_idx",   32'(col_idx),   32'h0);
            check("done_pix_valid", 32'(pix_valid), 32'h0);
            check("done_busy",      32'(busy),      32'h1);
            check("done_after_last", 32'(accepted), 32'(NPIX));
        end
    endtask

    task automatic run_image(input logic [31:0] addr, input int abort_after);
        int budget;
        exp_q.delete();
        exp_addr     = addr;
        req_seen     = 1'b0;
        rv_prev      = 1'b0;
        words_served = 0;
        accepted     = 0;
        done_pulses  = 0;
        budget       = 400;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        start      = 1'b1;
        start_addr = addr;
        pix_ready  = 1'b1;
        while (done_pulses == 0 && budget > 0) begin
            cycle();
            budget--;
            if (abort_after >= 0 && accepted >= abort_after) return;
        end
        if (budget == 0) check("timeout", 32'h0, 32'h1);
        cycle();
        cycle();
        check("busy_cleared", 32'(busy),        32'h0);
        check("idle_row_idx", 32'(row_idx),     32'h0);
        check("idle_col_idx", 32'(col_idx),     32'h0);
        check("done_pulses",  32'(done_pulses), 32'h1);
        check("queue_empty",  32'(exp_q.size()), 32'h0);
        check("pix_count",    32'(accepted),    32'(NPIX));
        check("words_read",   32'(words_served), 32'd4);
    endtask

    initial begin
        stall_at   = -1;
        stall_left = 0;
        slow_word  = -1;
        slow_lat   = 1;
        spur_at    = -1;
        spur_done  = 1'b1;

        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        n_rst = 1'b1;

        // Plain image: ready always high, one-cycle read latency.
        run_image(32'h100, -1);

        // Back-pressure on 0xBB, slow second read, stray start/read_valid mid-word.
        stall_at   = 1;
        stall_left = 5;
        slow_word  = 1;
        slow_lat   = 4;
        spur_at    = 5;
        spur_done  = 1'b0;
        run_image(32'h100, -1);
        check("stall_consumed", 32'(stall_left), 32'h0);
        check("spurious_sent",  32'(spur_done),  32'h1);

        // Abort after 6 pixels with reset, then a fresh image elsewhere.
        stall_at  = -1;
        slow_word = -1;
        spur_done = 1'b1;
        run_image(32'h300, 6);
        @(negedge clk);
        n_rst = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        check_zero("mid_reset_hold");
        check("no_partial_done", 32'(done_pulses), 32'h0);
        n_rst = 1'b1;
        run_image(32'h200, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
